// File: rtl/pcm1771_i2s_tx.sv
// pcm1771_i2s_tx: I2S serializer for the PCM1771 DAC with DAC_PD power-up sequencing and FIFO underrun flag
// Ports:
//   clock       dac_clock (128fs); all logic on its rising edge
//   reset_n     asynchronous active-low reset
//   data_ready  FIFO not empty
//   data_rdreq  single-cycle FIFO read request, issued once per frame
//   data_L/R    two's complement sample pair from the FIFO, valid the cycle after data_rdreq
//   DAC_PD      DAC power-down (low = powered down)
//   DAC_SCKI    system clock to the DAC, equal to clock
//   DAC_BCK     bit clock (64fs), DAC_LRCK word clock (low = left), DAC_DATA serial data, MSB first
//   underrun    one-cycle pulse when a frame had no sample to fetch
module pcm1771_i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int PD_DELAY   = 4096
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  data_ready,
  output logic                  data_rdreq,
  input  logic [DATA_WIDTH-1:0] data_L,
  input  logic [DATA_WIDTH-1:0] data_R,
  output logic                  DAC_PD,
  output logic                  DAC_SCKI,
  output logic                  DAC_BCK,
  output logic                  DAC_LRCK,
  output logic                  DAC_DATA,
  output logic                  underrun
);
  localparam int CW = $clog2(PD_DELAY > 256 ? PD_DELAY : 256) + 1;
  localparam logic [4:0] DW = 5'(DATA_WIDTH);
  typedef enum logic [1:0] {PWRDN, WARM, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0] fc;
  logic [4:0] p;
  logic rd, rd_n, pd_n, bck_n, lrck_n, dat_n, rdreq_n, urun_n;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, sh_l, sh_r;
  logic [DATA_WIDTH-1:0] hold_l_n, hold_r_n, sh_l_n, sh_r_n;
  assign DAC_SCKI = clock;
  // In RUN the low seven bits of cnt are the frame position; p is the slot within the current channel.
  assign fc = cnt[6:0];
  assign p = fc[5:1];
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    rd_n = rd;
    pd_n = DAC_PD;
    bck_n = DAC_BCK;
    lrck_n = DAC_LRCK;
    dat_n = DAC_DATA;
    rdreq_n = 1'b0;
    urun_n = 1'b0;
    hold_l_n = hold_l;
    hold_r_n = hold_r;
    sh_l_n = sh_l;
    sh_r_n = sh_r;
    case (state)
      PWRDN: if (cnt == CW'(PD_DELAY - 1)) begin
        pd_n = 1'b1;
        cnt_n = '0;
        state_n = WARM;
      end
      WARM: if (cnt == CW'(255)) begin
        cnt_n = '0;
        state_n = RUN;
      end
      RUN: begin
        cnt_n = CW'(fc + 7'd1);
        bck_n = fc[0];
        lrck_n = fc[6];
        // Data only moves on the BCK falling edge (even fc); slot 0 is the I2S one-bit delay,
        // so the MSB of the active channel goes out at p=1 and the register shifts left per bit.
        if (!fc[0]) begin
          dat_n = 1'b0;
          if (p != 5'd0 && p <= DW) begin
            dat_n = fc[6] ? sh_r[DATA_WIDTH-1] : sh_l[DATA_WIDTH-1];
            if (fc[6]) sh_r_n = sh_r << 1;
            else sh_l_n = sh_l << 1;
          end
        end
        if (fc == 7'd124) begin
          rdreq_n = data_ready;
          rd_n = data_ready;
        end
        // A read issued at 124 is committed even if data_ready drops afterwards.
        if (fc == 7'd126) begin
          hold_l_n = rd ? data_L : '0;
          hold_r_n = rd ? data_R : '0;
          urun_n = !rd;
        end
        if (fc == 7'd127) begin
          sh_l_n = hold_l;
          sh_r_n = hold_r;
        end
      end
      default: state_n = PWRDN;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= PWRDN;
      cnt <= '0;
      rd <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      sh_l <= '0;
      sh_r <= '0;
      DAC_PD <= 1'b0;
      DAC_BCK <= 1'b0;
      DAC_LRCK <= 1'b0;
      DAC_DATA <= 1'b0;
      data_rdreq <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rd <= rd_n;
      hold_l <= hold_l_n;
      hold_r <= hold_r_n;
      sh_l <= sh_l_n;
      sh_r <= sh_r_n;
      DAC_PD <= pd_n;
      DAC_BCK <= bck_n;
      DAC_LRCK <= lrck_n;
      DAC_DATA <= dat_n;
      data_rdreq <= rdreq_n;
      underrun <= urun_n;
    end
  end
endmodule
